// File: rtl/serpent_pkg.sv
// Shared Serpent constants, S-box tables and small helpers for the round datapath.
package serpent_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned ROUND_W    = 5;
    localparam int unsigned NUM_ROUNDS = 32;
    localparam int unsigned LAST_ROUND = 31;
    localparam int unsigned STATE_W    = 4 * WORD_W;

    // Table direction for serpent_sbox_bitslice; the decryption path builds it with SBOX_DIR_INV.
    localparam bit SBOX_DIR_FWD = 1'b0;
    localparam bit SBOX_DIR_INV = 1'b1;

    localparam logic [3:0] SBOX [8][16] = '{
        '{4'd3,  4'd8,  4'd15, 4'd1,  4'd10, 4'd6,  4'd5,  4'd11,
          4'd14, 4'd13, 4'd4,  4'd2,  4'd7,  4'd0,  4'd9,  4'd12},
        '{4'd15, 4'd12, 4'd2,  4'd7,  4'd9,  4'd0,  4'd5,  4'd10,
          4'd1,  4'd11, 4'd14, 4'd8,  4'd6,  4'd13, 4'd3,  4'd4},
        '{4'd8,  4'd6,  4'd7,  4'd9,  4'd3,  4'd12, 4'd10, 4'd15,
          4'd13, 4'd1,  4'd14, 4'd4,  4'd0,  4'd11, 4'd5,  4'd2},
        '{4'd0,  4'd15, 4'd11, 4'd8,  4'd12, 4'd9,  4'd6,  4'd3,
          4'd13, 4'd1,  4'd2,  4'd4,  4'd10, 4'd7,  4'd5,  4'd14},
        '{4'd1,  4'd15, 4'd8,  4'd3,  4'd12, 4'd0,  4'd11, 4'd6,
          4'd2,  4'd5,  4'd4,  4'd10, 4'd9,  4'd14, 4'd7,  4'd13},
        '{4'd15, 4'd5,  4'd2,  4'd11, 4'd4,  4'd10, 4'd9,  4'd12,
          4'd0,  4'd3,  4'd14, 4'd8,  4'd13, 4'd6,  4'd7,  4'd1},
        '{4'd7,  4'd2,  4'd12, 4'd5,  4'd8,  4'd4,  4'd6,  4'd11,
          4'd14, 4'd9,  4'd1,  4'd15, 4'd13, 4'd3,  4'd10, 4'd0},
        '{4'd1,  4'd13, 4'd15, 4'd0,  4'd14, 4'd8,  4'd2,  4'd11,
          4'd7,  4'd4,  4'd12, 4'd10, 4'd9,  4'd3,  4'd5,  4'd6}
    };

    typedef struct packed {
        logic [STATE_W-1:0] state;
        logic [ROUND_W-1:0] round;
        logic               last;
    } beat_t;

    function automatic logic [STATE_W-1:0] pack_state(
        input logic [WORD_W-1:0] w0,
        input logic [WORD_W-1:0] w1,
        input logic [WORD_W-1:0] w2,
        input logic [WORD_W-1:0] w3
    );
        return {w3, w2, w1, w0};
    endfunction

    // Inverse lookup by search; every box is a permutation, so exactly one entry matches.
    function automatic logic [3:0] sbox_inv(input logic [2:0] box, input logic [3:0] v);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (SBOX[box][i] == v) r = 4'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/serpent_sbox_bitslice.sv
// Combinational bitsliced Serpent S-box: bit j of each word forms one nibble, word_0 as LSB.
module serpent_sbox_bitslice
    import serpent_pkg::*;
#(
    parameter bit INVERSE = SBOX_DIR_FWD
) (
    input  logic [WORD_W-1:0] word_0_i,
    input  logic [WORD_W-1:0] word_1_i,
    input  logic [WORD_W-1:0] word_2_i,
    input  logic [WORD_W-1:0] word_3_i,
    input  logic [2:0]        box_i,
    output logic [WORD_W-1:0] word_0_o,
    output logic [WORD_W-1:0] word_1_o,
    output logic [WORD_W-1:0] word_2_o,
    output logic [WORD_W-1:0] word_3_o
);

    logic [3:0] nib;
    logic [3:0] sub;

    always_comb begin
        nib      = '0;
        sub      = '0;
        word_0_o = '0;
        word_1_o = '0;
        word_2_o = '0;
        word_3_o = '0;
        for (int j = 0; j < int'(WORD_W); j++) begin
            nib = {word_3_i[j], word_2_i[j], word_1_i[j], word_0_i[j]};
            sub = INVERSE ? sbox_inv(box_i, nib) : SBOX[box_i][nib];
            word_0_o[j] = sub[0];
            word_1_o[j] = sub[1];
            word_2_o[j] = sub[2];
            word_3_o[j] = sub[3];
        end
    end

endmodule

// File: rtl/serpent_keymix_sbox.sv
// Serpent key mix + S-box stage with a registered output and skid buffer.
// Define SERPENT_FINAL_KEYMIX_EN to fold the K_32 whitening into round 31.
module serpent_keymix_sbox
    import serpent_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [WORD_W-1:0]   i_word_0,
    input  logic [WORD_W-1:0]   i_word_1,
    input  logic [WORD_W-1:0]   i_word_2,
    input  logic [WORD_W-1:0]   i_word_3,
    input  logic [STATE_W-1:0]  i_subkey,
    input  logic [ROUND_W-1:0]  i_round,
`ifdef SERPENT_FINAL_KEYMIX_EN
    input  logic [STATE_W-1:0]  i_subkey_last,
`endif
    output logic                o_valid,
    input  logic                i_ready,
    output logic [WORD_W-1:0]   o_word_0,
    output logic [WORD_W-1:0]   o_word_1,
    output logic [WORD_W-1:0]   o_word_2,
    output logic [WORD_W-1:0]   o_word_3,
    output logic [ROUND_W-1:0]  o_round,
    output logic                o_last
);

    logic [STATE_W-1:0] mix;
    logic [WORD_W-1:0]  sub_0, sub_1, sub_2, sub_3;
    beat_t              new_beat;

    beat_t main_q, main_d;
    beat_t skid_q, skid_d;
    logic  main_valid_q, main_valid_d;
    logic  skid_valid_q, skid_valid_d;
    logic  ready_q;

    logic accept;
    logic main_free;

    assign mix = pack_state(i_word_0, i_word_1, i_word_2, i_word_3) ^ i_subkey;

    serpent_sbox_bitslice #(
        .INVERSE (SBOX_DIR_FWD)
    ) u_sbox (
        .word_0_i (mix[0*WORD_W +: WORD_W]),
        .word_1_i (mix[1*WORD_W +: WORD_W]),
        .word_2_i (mix[2*WORD_W +: WORD_W]),
        .word_3_i (mix[3*WORD_W +: WORD_W]),
        .box_i    (i_round[2:0]),
        .word_0_o (sub_0),
        .word_1_o (sub_1),
        .word_2_o (sub_2),
        .word_3_o (sub_3)
    );

    always_comb begin
        new_beat       = '0;
        new_beat.last  = (i_round == ROUND_W'(LAST_ROUND));
        new_beat.round = i_round;
        new_beat.state = pack_state(sub_0, sub_1, sub_2, sub_3);
`ifdef SERPENT_FINAL_KEYMIX_EN
        if (new_beat.last) new_beat.state = new_beat.state ^ i_subkey_last;
`endif
    end

    assign accept    = i_valid && ready_q;
    assign main_free = !main_valid_q || i_ready;

    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (main_free) begin
            if (skid_valid_q) begin
                // Skid is older than any incoming beat, so it refills main first.
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = accept;
                if (accept) skid_d = new_beat;
            end else begin
                main_valid_d = accept;
                if (accept) main_d = new_beat;
            end
        end else if (accept) begin
            skid_d       = new_beat;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= !skid_valid_d;
        end
    end

    assign o_ready  = ready_q;
    assign o_valid  = main_valid_q;
    assign o_word_0 = main_q.state[0*WORD_W +: WORD_W];
    assign o_word_1 = main_q.state[1*WORD_W +: WORD_W];
    assign o_word_2 = main_q.state[2*WORD_W +: WORD_W];
    assign o_word_3 = main_q.state[3*WORD_W +: WORD_W];
    assign o_round  = main_q.round;
    assign o_last   = main_q.last;

endmodule

// File: tb/tb_serpent_keymix_sbox.sv
// Scoreboard bench for serpent_keymix_sbox: driver queues expected beats, monitor checks outputs.
module tb_serpent_keymix_sbox;

    typedef struct packed {
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
        logic [4:0]  rnd;
        logic        last;
    } exp_t;

    localparam logic [3:0] TB_SBOX [8][16] = '{
        '{4'd3, 4'd8, 4'd15, 4'd1, 4'd10, 4'd6, 4'd5, 4'd11, 4'd14, 4'd13, 4'd4, 4'd2, 4'd7, 4'd0, 4'd9, 4'd12},
        '{4'd15, 4'd12, 4'd2, 4'd7, 4'd9, 4'd0, 4'd5, 4'd10, 4'd1, 4'd11, 4'd14, 4'd8, 4'd6, 4'd13, 4'd3, 4'd4},
        '{4'd8, 4'd6, 4'd7, 4'd9, 4'd3, 4'd12, 4'd10, 4'd15, 4'd13, 4'd1, 4'd14, 4'd4, 4'd0, 4'd11, 4'd5, 4'd2},
        '{4'd0, 4'd15, 4'd11, 4'd8, 4'd12, 4'd9, 4'd6, 4'd3, 4'd13, 4'd1, 4'd2, 4'd4, 4'd10, 4'd7, 4'd5, 4'd14},
        '{4'd1, 4'd15, 4'd8, 4'd3, 4'd12, 4'd0, 4'd11, 4'd6, 4'd2, 4'd5, 4'd4, 4'd10, 4'd9, 4'd14, 4'd7, 4'd13},
        '{4'd15, 4'd5, 4'd2, 4'd11, 4'd4, 4'd10, 4'd9, 4'd12, 4'd0, 4'd3, 4'd14, 4'd8, 4'd13, 4'd6, 4'd7, 4'd1},
        '{4'd7, 4'd2, 4'd12, 4'd5, 4'd8, 4'd4, 4'd6, 4'd11, 4'd14, 4'd9, 4'd1, 4'd15, 4'd13, 4'd3, 4'd10, 4'd0},
        '{4'd1, 4'd13, 4'd15, 4'd0, 4'd14, 4'd8, 4'd2, 4'd11, 4'd7, 4'd4, 4'd12, 4'd10, 4'd9, 4'd3, 4'd5, 4'd6}
    };

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready_dut, out_valid, out_ready;
    logic [31:0]  w0, w1, w2, w3;
    logic [127:0] subkey, subkey_last;
    logic [4:0]   round;
    logic [31:0]  ow0, ow1, ow2, ow3;
    logic [4:0]   oround;
    logic         olast;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_in     = 0;
    int   n_out    = 0;
    bit   mon_en   = 1'b0;
    bit   rand_ready = 1'b0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    serpent_keymix_sbox dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_valid       (in_valid),
        .o_ready       (in_ready_dut),
        .i_word_0      (w0),
        .i_word_1      (w1),
        .i_word_2      (w2),
        .i_word_3      (w3),
        .i_subkey      (subkey),
        .i_round       (round),
`ifdef SERPENT_FINAL_KEYMIX_EN
        .i_subkey_last (subkey_last),
`endif
        .o_valid       (out_valid),
        .i_ready       (out_ready),
        .o_word_0      (ow0),
        .o_word_1      (ow1),
        .o_word_2      (ow2),
        .o_word_3      (ow3),
        .o_round       (oround),
        .o_last        (olast)
    );

    function automatic exp_t model(input logic [31:0] a0, input logic [31:0] a1,
                                   input logic [31:0] a2, input logic [31:0] a3,
                                   input logic [127:0] k, input logic [4:0] r,
                                   input logic [127:0] kl);
        exp_t        e;
        logic [31:0] m0, m1, m2, m3;
        logic [3:0]  n, s;
        m0 = a0 ^ k[31:0];
        m1 = a1 ^ k[63:32];
        m2 = a2 ^ k[95:64];
        m3 = a3 ^ k[127:96];
        e = '0;
        for (int j = 0; j < 32; j++) begin
            n = {m3[j], m2[j], m1[j], m0[j]};
            s = TB_SBOX[r[2:0]][n];
            e.w0[j] = s[0];
            e.w1[j] = s[1];
            e.w2[j] = s[2];
            e.w3[j] = s[3];
        end
        e.rnd  = r;
        e.last = (r == 5'd31);
`ifdef SERPENT_FINAL_KEYMIX_EN
        if (e.last) begin
            e.w0 = e.w0 ^ kl[31:0];
            e.w1 = e.w1 ^ kl[63:32];
            e.w2 = e.w2 ^ kl[95:64];
            e.w3 = e.w3 ^ kl[127:96];
        end
`endif
        return e;
    endfunction

    task automatic check(input bit ok, input string name, input string act, input string req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %s, required %s", name, act, req);
    endtask

    // Holds the beat on the inputs until the DUT takes it; the expectation is queued on accept.
    task automatic send_beat(input logic [31:0] a0, input logic [31:0] a1,
                             input logic [31:0] a2, input logic [31:0] a3,
                             input logic [127:0] k, input logic [4:0] r,
                             input logic [127:0] kl, input exp_t e);
        bit acc;
        acc = 1'b0;
        w0 = a0; w1 = a1; w2 = a2; w3 = a3;
        subkey = k; round = r; subkey_last = kl;
        in_valid = 1'b1;
        for (int c = 0; c < 200 && !acc; c++) begin
            @(negedge clk);
            if (in_ready_dut) begin
                acc = 1'b1;
                exp_q.push_back(e);
                n_in++;
            end
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0;
        if (!acc) check(1'b0, "accept_timeout", "no accept in 200 cycles", "accept");
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en && out_valid) begin
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_beat",
                      $sformatf("%h %h %h %h r%0d", ow0, ow1, ow2, ow3, oround), "no beat");
            end else begin
                e = exp_q[0];
                check({ow0, ow1, ow2, ow3, oround, olast} == e, "beat_data",
                      $sformatf("%h %h %h %h r%0d l%0b", ow0, ow1, ow2, ow3, oround, olast),
                      $sformatf("%h %h %h %h r%0d l%0b", e.w0, e.w1, e.w2, e.w3, e.rnd, e.last));
                if (out_ready) begin
                    exp_q.delete(0);
                    n_out++;
                end
            end
        end
    end

    task automatic directed(input logic [31:0] a0, input logic [31:0] a1,
                            input logic [31:0] a2, input logic [31:0] a3,
                            input logic [127:0] k, input logic [4:0] r, input exp_t e);
        send_beat(a0, a1, a2, a3, k, r, 128'h0, e);
        check(out_valid == 1'b1, "latency_1", $sformatf("o_valid=%0b", out_valid), "1");
    endtask

    initial begin
        exp_t e;
        logic [31:0]  ra0, ra1, ra2, ra3;
        logic [127:0] rk, rkl;
        logic [4:0]   rr;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        w0 = '0; w1 = '0; w2 = '0; w3 = '0;
        subkey = '0; subkey_last = '0; round = '0;
        repeat (2) @(posedge clk);
        #1;
        check({out_valid, in_ready_dut} == 2'b01, "reset_handshake",
              $sformatf("o_valid=%0b o_ready=%0b", out_valid, in_ready_dut), "o_valid=0 o_ready=1");
        check({ow0, ow1, ow2, ow3, oround, olast} == '0, "reset_data",
              $sformatf("%h %h %h %h r%0d l%0b", ow0, ow1, ow2, ow3, oround, olast), "all zero");
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Hand-computed single-beat vectors.
        directed('0, '0, '0, '0, '0, 5'd0,
                 '{w0: 32'hFFFFFFFF, w1: 32'hFFFFFFFF, w2: 32'h0, w3: 32'h0, rnd: 5'd0, last: 1'b0});
        directed(32'hFFFFFFFF, '0, '0, '0, '0, 5'd8,
                 '{w0: 32'h0, w1: 32'h0, w2: 32'h0, w3: 32'hFFFFFFFF, rnd: 5'd8, last: 1'b0});
        directed('0, '0, '0, '0, 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 5'd0,
                 '{w0: 32'h0, w1: 32'h0, w2: 32'h0, w3: 32'hFFFFFFFF, rnd: 5'd0, last: 1'b0});
        directed('0, '0, '0, '0, '0, 5'd1,
                 '{w0: 32'hFFFFFFFF, w1: 32'hFFFFFFFF, w2: 32'hFFFFFFFF, w3: 32'hFFFFFFFF,
                   rnd: 5'd1, last: 1'b0});
        directed(32'h0000FFFF, '0, '0, '0, '0, 5'd2,
                 '{w0: 32'h0, w1: 32'h0000FFFF, w2: 32'h0000FFFF, w3: 32'hFFFF0000,
                   rnd: 5'd2, last: 1'b0});
        directed('0, 32'hFFFFFFFF, '0, '0, 128'h0000_0000_0000_0000_FFFF_FFFF_0000_0000, 5'd7,
                 '{w0: 32'hFFFFFFFF, w1: 32'h0, w2: 32'h0, w3: 32'h0, rnd: 5'd7, last: 1'b0});

        // Stall: two accepts fill main and skid, then the input side must back off.
        out_ready = 1'b1;
        send_beat(32'h1111_1111, '0, '0, '0, '0, 5'd3,
                  '0, model(32'h1111_1111, '0, '0, '0, '0, 5'd3, '0));
        out_ready = 1'b0;
        send_beat('0, 32'h2222_2222, '0, '0, '0, 5'd4,
                  '0, model('0, 32'h2222_2222, '0, '0, '0, 5'd4, '0));
        check(in_ready_dut == 1'b0, "ready_falls", $sformatf("o_ready=%0b", in_ready_dut), "0");
        repeat (3) begin
            @(negedge clk);
            check(in_ready_dut == 1'b0 && out_valid == 1'b1, "stall_hold",
                  $sformatf("o_ready=%0b o_valid=%0b", in_ready_dut, out_valid), "o_ready=0 o_valid=1");
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_beat('0, '0, 32'h3333_3333, '0, '0, 5'd5,
                  '0, model('0, '0, 32'h3333_3333, '0, '0, 5'd5, '0));
        send_beat('0, '0, '0, 32'h4444_4444, '0, 5'd6,
                  '0, model('0, '0, '0, 32'h4444_4444, '0, 5'd6, '0));

        // Round 31: S7(0)=1 puts ones in word_0; the optional K_32 clears bit 0.
`ifdef SERPENT_FINAL_KEYMIX_EN
        e = '{w0: 32'hFFFFFFFE, w1: 32'h0, w2: 32'h0, w3: 32'h0, rnd: 5'd31, last: 1'b1};
`else
        e = '{w0: 32'hFFFFFFFF, w1: 32'h0, w2: 32'h0, w3: 32'h0, rnd: 5'd31, last: 1'b1};
`endif
        send_beat('0, '0, '0, '0, '0, 5'd31, 128'h1, e);
        repeat (3) @(posedge clk);
        #1;

        // Reset with both registers full discards both beats.
        out_ready = 1'b0;
        send_beat(32'hDEAD_BEEF, '0, '0, '0, '0, 5'd9,
                  '0, model(32'hDEAD_BEEF, '0, '0, '0, '0, 5'd9, '0));
        send_beat(32'hCAFE_F00D, '0, '0, '0, '0, 5'd10,
                  '0, model(32'hCAFE_F00D, '0, '0, '0, '0, 5'd10, '0));
        mon_en = 1'b0;
        n_in = n_in - exp_q.size();
        exp_q.delete();
        rst_n = 1'b0;
        in_valid = 1'b1;
        w0 = 32'h5555_5555;
        @(posedge clk);
        #1;
        check({out_valid, in_ready_dut} == 2'b01, "midreset_flush",
              $sformatf("o_valid=%0b o_ready=%0b", out_valid, in_ready_dut), "o_valid=0 o_ready=1");
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        check(out_valid == 1'b0, "no_stale_beat", $sformatf("o_valid=%0b", out_valid), "0");

        // Random traffic with random downstream stalls against the reference model.
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            ra0 = $urandom; ra1 = $urandom; ra2 = $urandom; ra3 = $urandom;
            rk  = {$urandom, $urandom, $urandom, $urandom};
            rkl = {$urandom, $urandom, $urandom, $urandom};
            rr  = 5'($urandom_range(0, 31));
            send_beat(ra0, ra1, ra2, ra3, rk, rr, rkl, model(ra0, ra1, ra2, ra3, rk, rr, rkl));
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;

        for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge clk);
        #1;
        check(exp_q.size() == 0, "drain_empty", $sformatf("%0d pending", exp_q.size()), "0 pending");
        check(n_out == n_in, "beat_count", $sformatf("%0d out", n_out), $sformatf("%0d in", n_in));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
